// File: rtl/instruction_fetch_stage.sv
// ----------------------------------------------------------------------------
// instruction_fetch_stage
//   Front end of the 5-stage pipeline. Owns the program counter, drives the
//   asynchronous instruction ROM address and captures the returned word into
//   the IF/ID pipeline register. The next PC is chosen from reset, exception,
//   EX branch, ID jump, interrupt, stall-hold and sequential sources.
//
//   Optional feature macro: IRQ_EN
//     defined   : external interrupt entry (irq_take, irq_taken, irq_epc)
//     undefined : irq is ignored, irq_taken and irq_epc are tied to 0
//
// Ports
//   clk             in   system clock, all state on rising edge
//   reset           in   synchronous active-high reset
//   stall           in   load-use hazard: hold PC and IF/ID
//   flush           in   squash IF/ID contents
//   jump            in   ID jump resolved (ignored while stall)
//   jump_target     in   [31:0] jump destination
//   branch_taken    in   EX branch resolved taken (overrides stall)
//   branch_target   in   [31:0] branch destination
//   exception       in   ID undefined instruction
//   irq             in   level-sensitive interrupt request
//   inst_addr       out  [31:0] current PC to ROM
//   inst_data       in   [31:0] ROM word, combinational from inst_addr
//   if_id_inst      out  [31:0] registered instruction
//   if_id_pc_plus4  out  [31:0] registered PC+4 of that instruction
//   if_id_valid     out  1 = real instruction, 0 = bubble
//   irq_taken       out  one-cycle pulse when an interrupt was accepted
//   irq_epc         out  [31:0] PC of the instruction squashed at entry
// ----------------------------------------------------------------------------
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] IRQ_VECTOR = 32'h8000_0004,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        exception,
  input  logic        irq,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_data,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        irq_taken,
  output logic [31:0] irq_epc
);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  // sll $0,$0,0 with valid cleared
  localparam if_id_t BUBBLE = '{inst: 32'h0, pc_plus4: 32'h0, valid: 1'b0};

  logic [31:0] pc, pc_next, pc_plus4;
  if_id_t      if_id, if_id_next;
  logic        irq_take;
  logic        jump_eff;
  logic        squash;

  assign pc_plus4  = pc + 32'd4;   // natural wrap at 2^32
  assign inst_addr = pc;
  assign jump_eff  = jump & ~stall;

`ifdef IRQ_EN
  // Kernel mode (PC[31]) masks the request; any hazard or redirect defers it
  // and the level-sensitive request is simply retried next cycle.
  assign irq_take = irq & ~pc[31] & ~stall & ~flush & ~exception
                  & ~branch_taken & ~jump;
`else
  assign irq_take = 1'b0 & irq;
`endif

  // Anything that redirects or kills the current fetch yields a bubble.
  assign squash = exception | branch_taken | flush | jump_eff | irq_take;

  always_comb begin
    pc_next = pc_plus4;
    if (exception)         pc_next = EXC_VECTOR;
    else if (branch_taken) pc_next = branch_target;
    else if (jump_eff)     pc_next = jump_target;
    else if (irq_take)     pc_next = IRQ_VECTOR;
    else if (stall)        pc_next = pc;
  end

  always_comb begin
    if_id_next = '{inst: inst_data, pc_plus4: pc_plus4, valid: 1'b1};
    if (squash)     if_id_next = BUBBLE;
    else if (stall) if_id_next = if_id;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      if_id <= BUBBLE;
    end else begin
      pc    <= pc_next;
      if_id <= if_id_next;
    end
  end

  assign if_id_inst     = if_id.inst;
  assign if_id_pc_plus4 = if_id.pc_plus4;
  assign if_id_valid    = if_id.valid;

`ifdef IRQ_EN
  logic        irq_taken_q;
  logic [31:0] irq_epc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_taken_q <= 1'b0;
      irq_epc_q   <= 32'h0;
    end else begin
      irq_taken_q <= irq_take;
      if (irq_take) irq_epc_q <= pc;
    end
  end

  assign irq_taken = irq_taken_q;
  assign irq_epc   = irq_epc_q;
`else
  assign irq_taken = irq_take;
  assign irq_epc   = 32'h0;
`endif

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Front end of the 5-stage pipelined CPU. Holds the program counter and drives the instruction ROM's word address. Registers the returned instruction into the IF/ID pipeline register. Selects the next PC from sequential, jump (ID), branch (EX), exception and interrupt sources, and honours hazard stall and flush requests from the hazard unit.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- IRQ_VECTOR, 32'h8000_0004, interrupt handler entry; bit 31 = kernel mode
- EXC_VECTOR, 32'h8000_0008, exception handler entry
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  load-use hazard; hold PC and IF/ID
- flush  in  1  squash IF/ID contents
- jump  in  1  ID-stage jump/jr/jal resolved
- jump_target  in  32  jump destination
- branch_taken  in  1  EX-stage branch resolved taken
- branch_target  in  32  branch destination
- exception  in  1  ID-stage undefined instruction
- irq  in  1  level-sensitive external interrupt request
- inst_addr  out  32  current PC, to ROM Address (ROM indexes bits [11:2])
- inst_data  in  32  ROM Instruction, combinational from inst_addr
- if_id_inst  out  32  registered instruction
- if_id_pc_plus4  out  32  registered PC+4 of that instruction
- if_id_valid  out  1  1 = real instruction, 0 = bubble
- irq_taken  out  1  registered 1-cycle pulse when interrupt accepted
- irq_epc  out  32  PC of squashed instruction at interrupt entry

## Operation
- Bubble = {inst 32'h0000_0000 (sll $0,$0,0), pc_plus4 0, valid 0}.
- irq_take = irq & ~PC[31] & ~stall & ~flush & ~exception & ~branch_taken & ~jump.
- PC next-value priority, highest first:
  - reset -> RESET_PC
  - exception -> EXC_VECTOR
  - branch_taken -> branch_target (overrides stall)
  - jump & ~stall -> jump_target (jump ignored while stall)
  - irq_take -> IRQ_VECTOR
  - stall -> hold
  - else PC+4, modulo 2^32 (32'hFFFF_FFFC -> 0)
- IF/ID next value, highest first:
  - reset, exception, branch_taken, flush, (jump & ~stall), irq_take -> bubble
  - stall -> hold
  - else {inst_data, PC+4, 1}
- irq_epc: loads PC on irq_take, else holds. irq_taken = registered irq_take.
- Interrupts are masked while PC[31]=1 (kernel). irq held high during the handler does not re-trigger. A request blocked by stall/redirect is retried every cycle while irq stays high.
- No branch delay slot; the wrong-path fetch is always squashed.
- Target addresses are used unmodified; low two bits are not forced to zero.

## Timing
- Reset values: PC=RESET_PC, inst_addr=RESET_PC, if_id_* = bubble, irq_taken=0, irq_epc=0.
- inst_addr = PC combinationally; ROM is asynchronous, so fetch-to-IF/ID latency is 1 cycle.
- Redirect penalty: jump 1 bubble, branch 2 bubbles (squashed here plus ID squash by hazard unit), interrupt 1 bubble.
- Stall: PC and IF/ID frozen exactly for the asserted cycles; the first cycle after release loads inst_data at the unchanged PC.
- Reset asserted mid-stream wins over all inputs in the same cycle.

## Configuration
- IRQ_EN defined: interrupt logic as above.
- IRQ_EN undefined: irq ignored (port kept), irq_take=0, irq_taken tied 0, irq_epc tied 0, no epc register.

## Test plan
- Reset release, ROM word i = 32'h1000_0000+i -> inst_addr 0,4,8,…; if_id_inst 32'h1000_0000 one cycle after release, valid 1, pc_plus4 4.
- stall for 2 cycles at PC=0x10 -> PC holds 0x10, IF/ID holds the 0x0C entry (inst 32'h1000_0003, pc_plus4 0x10) for 2 cycles; next cycle loads 32'h1000_0004, pc_plus4 0x14.
- jump=1, target 0x40 at PC=0x20 -> next PC 0x40, IF/ID bubble; same with stall=1 -> PC holds 0x20, no redirect.
- branch_taken target 0x100 together with stall=1 -> PC=0x100, IF/ID bubble; exception in the same cycle -> PC=0x8000_0008 instead.
- irq=1 at PC=0x30, no hazards (IRQ_EN) -> PC=0x8000_0004, irq_epc=0x30, irq_taken 1 cycle, IF/ID bubble; irq kept high -> no second pulse while PC[31]=1.
- PC wrap: jump to 0xFFFF_FFFC -> next sequential PC 0x0000_0000, if_id_pc_plus4 0.
